core_store: RTL and testbench

Context store controller answering the CORE's STORE request interface (store_write / store_read / store_call, SA/SB/SC, store_busy). It drives the CORE's L1 loader port (L1_write, L1_read, L1_ADDR, L12loader) to copy the 4-word L1 scratchpad out to, or back from, a segment-indexed backing RAM. It stalls the instruction pointer through store_busy while a transfer runs. One instance per CORE, beside it at the top level.

---
 rtl/core_store_pkg.sv | 20 ++
 rtl/core_store_if.sv | 26 ++
 rtl/core_store_ram.sv | 30 +++
 rtl/core_store.sv | 106 ++++++++++
 tb/tb_core_store.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_store_pkg.sv
// Shared types and constants for the core_store context-store controller.
// Optional CALL support is selected by the STORE_CALL_EN macro (see core_store.sv).
package core_store_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    localparam int L1_DEPTH = 4;
    localparam int IDX_W    = $clog2(L1_DEPTH);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L1_DEPTH - 1);

    function automatic logic is_last(input logic [IDX_W-1:0] idx);
        return idx == LAST_IDX;
    endfunction

endpackage

// File: rtl/core_store_if.sv
// CORE <-> store request/handshake bundle; the CORE is the master, core_store the slave.
// The bidirectional L12loader data bus stays a plain inout port on the controller.
interface core_store_if #(
    parameter int SW = 4
);
    logic          store_write;
    logic          store_read;
    logic          store_call;
    logic [SW-1:0] SA;
    logic [SW-1:0] SB;
    logic [SW-1:0] SC;
    logic          store_busy;
    logic          L1_write;
    logic          L1_read;
    logic [1:0]    L1_ADDR;

    modport master (
        output store_write, store_read, store_call, SA, SB, SC,
        input  store_busy, L1_write, L1_read, L1_ADDR
    );

    modport slave (
        input  store_write, store_read, store_call, SA, SB, SC,
        output store_busy, L1_write, L1_read, L1_ADDR
    );
endinterface

// File: rtl/core_store_ram.sv
// Backing RAM for saved L1 contexts: async read, sync write, cleared by reset.
// Address is {segment, word index}.
module store_ram #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/core_store.sv
// Context store controller: copies the CORE's 4-word L1 to/from a segment-indexed RAM.
// Define STORE_CALL_EN to honour store_call (priority over write/read); otherwise SC is unused.
module core_store
    import core_store_pkg::*;
#(
    parameter int DW = 16,
    parameter int SW = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    core_store_if.slave   bus,
    inout  wire  [DW-1:0] L12loader
);
    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [SW-1:0]    seg_q;
    logic             l1_write_q;
    logic             l1_read_q;
    logic             req_call;
    logic             req_any;
    logic [DW-1:0]    rd_data;

`ifdef STORE_CALL_EN
    assign req_call = bus.store_call;
`else
    logic unused_call;
    assign req_call    = 1'b0;
    assign unused_call = ^{bus.store_call, bus.SC};
`endif

    assign req_any = req_call | bus.store_write | bus.store_read;

    // Busy drops on the last word so the IP advances on the completing edge.
    always_comb begin
        bus.store_busy = 1'b0;
        case (state_q)
            ST_IDLE: bus.store_busy = req_any;
            ST_SAVE,
            ST_LOAD: bus.store_busy = !is_last(idx_q);
            default: bus.store_busy = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            seg_q      <= '0;
            l1_write_q <= 1'b0;
            l1_read_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_q <= '0;
                    if (req_call) begin
                        seg_q      <= bus.SC;
                        state_q    <= ST_SAVE;
                        l1_write_q <= 1'b1;
                    end else if (bus.store_write) begin
                        seg_q      <= bus.SA;
                        state_q    <= ST_SAVE;
                        l1_write_q <= 1'b1;
                    end else if (bus.store_read) begin
                        seg_q     <= bus.SB;
                        state_q   <= ST_LOAD;
                        l1_read_q <= 1'b1;
                    end
                end
                ST_SAVE,
                ST_LOAD: begin
                    idx_q <= idx_q + 1'b1;
                    if (is_last(idx_q)) begin
                        state_q    <= ST_IDLE;
                        l1_write_q <= 1'b0;
                        l1_read_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    l1_write_q <= 1'b0;
                    l1_read_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.L1_write = l1_write_q;
    assign bus.L1_read  = l1_read_q;
    assign bus.L1_ADDR  = idx_q;

    store_ram #(
        .DW (DW),
        .AW (SW + IDX_W)
    ) u_ram (
        .clk     (CLK),
        .rst_n   (RESET),
        .we_i    (l1_write_q),
        .addr_i  ({seg_q, idx_q}),
        .wdata_i (L12loader),
        .rdata_o (rd_data)
    );

    // Only drive the shared bus while the CORE is latching a LOAD word.
    assign L12loader = l1_read_q ? rd_data : {DW{1'bz}};

endmodule

// File: tb/tb_core_store.sv
// Self-checking bench for core_store: a CORE model with its own L1 and a RAM model/scoreboard.
module tb_core_store;

    localparam int DW = 16;
    localparam int SW = 4;
`ifdef STORE_CALL_EN
    localparam bit CALL_EN = 1'b1;
`else
    localparam bit CALL_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    wire  [DW-1:0] L12loader;

    core_store_if #(.SW(SW)) bus ();

    core_store #(.DW(DW), .SW(SW)) dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .bus       (bus),
        .L12loader (L12loader)
    );

    logic [DW-1:0] core_l1 [4];
    logic [DW-1:0] mem_m   [16][4];
    logic [DW-1:0] exp_q   [$];
    int checks;
    int errors;

    assign L12loader = bus.L1_write ? core_l1[bus.L1_ADDR] : {DW{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_l1(input logic [DW-1:0] a, b, c, d);
        core_l1[0] = a; core_l1[1] = b; core_l1[2] = c; core_l1[3] = d;
    endtask

    // Drives one request at the current negedge (T0) and checks T0..T4; returns at the T5 negedge.
    task automatic xfer(input string name, input logic w, r, c, input logic [SW-1:0] sa, sb, sc);
        int kind;
        logic [SW-1:0] seg;
        logic exp_busy, exp_wr, exp_rd;
        logic [1:0] exp_addr;
        logic [DW-1:0] got, exp;
        kind = 0;
        seg  = '0;
        if (c && CALL_EN) begin kind = 1; seg = sc; end
        else if (w)       begin kind = 1; seg = sa; end
        else if (r)       begin kind = 2; seg = sb; end
        if (kind == 1) for (int i = 0; i < 4; i++) mem_m[seg][i] = core_l1[i];
        if (kind == 2) for (int i = 0; i < 4; i++) exp_q.push_back(mem_m[seg][i]);
        bus.store_write = w; bus.store_read = r; bus.store_call = c;
        bus.SA = sa; bus.SB = sb; bus.SC = sc;
        for (int t = 0; t < 5; t++) begin
            #1;
            exp_busy = (kind != 0) && (t < 4);
            exp_wr   = (kind == 1) && (t > 0);
            exp_rd   = (kind == 2) && (t > 0);
            exp_addr = (kind != 0 && t > 0) ? 2'(t - 1) : 2'd0;
            checks++;
            if (bus.store_busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy T%0d: got %b want %b", name, t, bus.store_busy, exp_busy);
            end
            checks++;
            if (bus.L1_write !== exp_wr || bus.L1_read !== exp_rd) begin
                errors++;
                $display("FAIL %s wr/rd T%0d: got %b/%b want %b/%b", name, t,
                         bus.L1_write, bus.L1_read, exp_wr, exp_rd);
            end
            checks++;
            if (bus.L1_ADDR !== exp_addr) begin
                errors++;
                $display("FAIL %s addr T%0d: got %0d want %0d", name, t, bus.L1_ADDR, exp_addr);
            end
            if (kind == 2 && t > 0) begin
                got = L12loader;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s data T%0d: got %0d want %0d", name, t, got, exp);
                end
                core_l1[t-1] = got;
            end
            @(negedge clk);
            bus.store_call = 1'b0;
        end
    endtask

    task automatic idle_cycle(input string name);
        bus.store_write = 1'b0; bus.store_read = 1'b0; bus.store_call = 1'b0;
        #1;
        checks++;
        if (bus.store_busy !== 1'b0 || bus.L1_write !== 1'b0 || bus.L1_read !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: got busy=%b wr=%b rd=%b want 0/0/0", name,
                     bus.store_busy, bus.L1_write, bus.L1_read);
        end
        @(negedge clk);
    endtask

    task automatic check_l1(input string name, input logic [DW-1:0] a, b, c, d);
        logic [DW-1:0] want [4];
        want[0] = a; want[1] = b; want[2] = c; want[3] = d;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (core_l1[i] !== want[i]) begin
                errors++;
                $display("FAIL %s L1[%0d]: got %0d want %0d", name, i, core_l1[i], want[i]);
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 16; s++) for (int i = 0; i < 4; i++) mem_m[s][i] = '0;
        set_l1('0, '0, '0, '0);
        bus.store_write = 0; bus.store_read = 0; bus.store_call = 0;
        bus.SA = '0; bus.SB = '0; bus.SC = '0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.store_busy !== 1'b0 || bus.L1_write !== 1'b0 || bus.L1_read !== 1'b0 ||
            bus.L1_ADDR !== 2'd0) begin
            errors++;
            $display("FAIL reset outputs: got busy=%b wr=%b rd=%b addr=%0d want 0/0/0/0",
                     bus.store_busy, bus.L1_write, bus.L1_read, bus.L1_ADDR);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_save();
        set_l1(16'd11, 16'd22, 16'd33, 16'd44);
        xfer("save", 1'b1, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0);
        idle_cycle("save_end");
    endtask

    task automatic test_load();
        set_l1('0, '0, '0, '0);
        xfer("load", 1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 4'd0);
        idle_cycle("load_end");
        check_l1("load", 16'd11, 16'd22, 16'd33, 16'd44);
    endtask

    task automatic test_priority();
        set_l1(16'h0a0a, 16'h0b0b, 16'h0c0c, 16'h0d0d);
        xfer("prio", 1'b1, 1'b1, 1'b0, 4'd2, 4'd3, 4'd0);
        idle_cycle("prio_end");
        set_l1('1, '1, '1, '1);
        xfer("prio_seg3", 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0);
        idle_cycle("prio_seg3_end");
        check_l1("prio_seg3", '0, '0, '0, '0);
        xfer("prio_seg2", 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 4'd0);
        idle_cycle("prio_seg2_end");
        check_l1("prio_seg2", 16'h0a0a, 16'h0b0b, 16'h0c0c, 16'h0d0d);
    endtask

    task automatic test_call();
        set_l1(16'd1, 16'd2, 16'd3, 16'd4);
        xfer("call", 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7);
        idle_cycle("call_end");
        set_l1('1, '1, '1, '1);
        xfer("call_rd", 1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 4'd0);
        idle_cycle("call_rd_end");
        if (CALL_EN) check_l1("call_rd", 16'd1, 16'd2, 16'd3, 16'd4);
        else         check_l1("call_rd", '0, '0, '0, '0);
    endtask

    task automatic test_reset_mid_load();
        bus.store_read = 1'b1; bus.SB = 4'd5;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.store_read = 1'b0;
        #1;
        checks++;
        if (bus.L1_read !== 1'b0 || bus.store_busy !== 1'b0 || bus.L1_ADDR !== 2'd0) begin
            errors++;
            $display("FAIL midreset: got rd=%b busy=%b addr=%0d want 0/0/0",
                     bus.L1_read, bus.store_busy, bus.L1_ADDR);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 16; s++) for (int i = 0; i < 4; i++) mem_m[s][i] = '0;
        @(negedge clk);
        set_l1('1, '1, '1, '1);
        xfer("midreset_rd", 1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 4'd0);
        idle_cycle("midreset_rd_end");
        check_l1("midreset_rd", '0, '0, '0, '0);
    endtask

    task automatic test_back_to_back();
        set_l1(16'hbeef, 16'h1234, 16'hffff, 16'h0001);
        xfer("b2b_save", 1'b1, 1'b0, 1'b0, 4'd15, 4'd0, 4'd0);
        set_l1('0, '0, '0, '0);
        xfer("b2b_load", 1'b0, 1'b1, 1'b0, 4'd0, 4'd15, 4'd0);
        idle_cycle("b2b_end");
        check_l1("b2b", 16'hbeef, 16'h1234, 16'hffff, 16'h0001);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_save();
        test_load();
        test_priority();
        test_call();
        test_reset_mid_load();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: got %0d leftover words want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
